// File: rtl/tri_pkg.sv
// Shared types and edge arithmetic for the triangle rasteriser.
package tri_pkg;

  typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, SETUP, SCAN, DONE} state_t;

  // Edge math is sized for the widest supported coordinate so one function
  // serves every CW.
  // Narrower instances zero-extend into it, and the unused high bits fold
  // away as constants.
  localparam int CW_MAX = 12;
  localparam int EW     = 2*CW_MAX+3;

  function automatic logic signed [EW-1:0] zx(input logic [CW_MAX-1:0] v);
    return $signed({{(EW-CW_MAX){1'b0}}, v});
  endfunction

  // Eab(p) = (xb-xa)*(py-ya) - (yb-ya)*(px-xa).
  // Every partial result fits EW bits signed, so the result is exact.
  function automatic logic signed [EW-1:0] edge_fn(
    input logic [CW_MAX-1:0] xa, input logic [CW_MAX-1:0] ya,
    input logic [CW_MAX-1:0] xb, input logic [CW_MAX-1:0] yb,
    input logic [CW_MAX-1:0] px, input logic [CW_MAX-1:0] py);
    logic signed [EW-1:0] dxb, dyp, dyb, dxp;
    dxb = zx(xb) - zx(xa);
    dyp = zx(py) - zx(ya);
    dyb = zx(yb) - zx(ya);
    dxp = zx(px) - zx(xa);
    return (dxb * dyp) - (dyb * dxp);
  endfunction

endpackage

// File: rtl/tri_edge_eval.sv
// Combinational coverage test of one cursor position against three edges.
module tri_edge_eval
  import tri_pkg::*;
#(
  parameter int CW = 3
)(
  input  logic [CW-1:0] i_x0,
  input  logic [CW-1:0] i_y0,
  input  logic [CW-1:0] i_x1,
  input  logic [CW-1:0] i_y1,
  input  logic [CW-1:0] i_x2,
  input  logic [CW-1:0] i_y2,
  input  logic [CW-1:0] i_px,
  input  logic [CW-1:0] i_py,
  output logic          o_cov
);

  logic signed [EW-1:0] w_e01, w_e12, w_e20;
  logic                 w_all_ge, w_all_le;

  assign w_e01 = edge_fn(CW_MAX'(i_x0), CW_MAX'(i_y0), CW_MAX'(i_x1), CW_MAX'(i_y1),
                         CW_MAX'(i_px), CW_MAX'(i_py));
  assign w_e12 = edge_fn(CW_MAX'(i_x1), CW_MAX'(i_y1), CW_MAX'(i_x2), CW_MAX'(i_y2),
                         CW_MAX'(i_px), CW_MAX'(i_py));
  assign w_e20 = edge_fn(CW_MAX'(i_x2), CW_MAX'(i_y2), CW_MAX'(i_x0), CW_MAX'(i_y0),
                         CW_MAX'(i_px), CW_MAX'(i_py));

  // Accepting "all >= 0" or "all <= 0" covers both windings.
  // Zero-valued edges keep boundary pixels inside.
  assign w_all_ge = !w_e01[EW-1] && !w_e12[EW-1] && !w_e20[EW-1];
  assign w_all_le = (w_e01[EW-1] || (w_e01 == '0)) &&
                    (w_e12[EW-1] || (w_e12 == '0)) &&
                    (w_e20[EW-1] || (w_e20 == '0));
  assign o_cov    = w_all_ge || w_all_le;

endmodule

// File: rtl/tri_raster_gen.sv
// Bounding-box triangle rasteriser with a valid/ready pixel output.
module tri_raster_gen
  import tri_pkg::*;
#(
  parameter int CW    = 3,
  parameter int CNT_W = 2*CW+1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             nt,
  input  logic [CW-1:0]    xi,
  input  logic [CW-1:0]    yi,
  input  logic             out_rdy,
  output logic             busy,
  output logic             po,
  output logic [CW-1:0]    xo,
  output logic [CW-1:0]    yo,
  output logic             done,
  output logic [CNT_W-1:0] pix_cnt
);

  state_t               r_state, w_nxt;
  logic [CW-1:0]        r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic [CW-1:0]        r_xmin, r_xmax, r_ymin, r_ymax;
  logic [CW-1:0]        r_cx, r_cy;
  logic                 r_last;
  logic                 r_po;
  logic [CW-1:0]        r_xo, r_yo;
  logic [CNT_W-1:0]     r_cnt;

  logic [CW-1:0]        w_xmin, w_xmax, w_ymin, w_ymax;
  logic signed [EW-1:0] w_area;
  logic                 w_cov, w_stall, w_acc, w_row_end, w_box_end;

  // Bounding box of the three captured vertices.
  always_comb begin
    w_xmin = r_x0;
    w_xmax = r_x0;
    w_ymin = r_y0;
    w_ymax = r_y0;
    if (r_x1 < w_xmin) w_xmin = r_x1;
    if (r_x2 < w_xmin) w_xmin = r_x2;
    if (r_x1 > w_xmax) w_xmax = r_x1;
    if (r_x2 > w_xmax) w_xmax = r_x2;
    if (r_y1 < w_ymin) w_ymin = r_y1;
    if (r_y2 < w_ymin) w_ymin = r_y2;
    if (r_y1 > w_ymax) w_ymax = r_y1;
    if (r_y2 > w_ymax) w_ymax = r_y2;
  end

  // Twice the signed area. It is only consumed in SETUP, to reject degenerate
  // triangles before any scanning starts.
  assign w_area = edge_fn(CW_MAX'(r_x0), CW_MAX'(r_y0), CW_MAX'(r_x1), CW_MAX'(r_y1),
                          CW_MAX'(r_x2), CW_MAX'(r_y2));

  tri_edge_eval #(.CW(CW)) u_eval (
    .i_x0 (r_x0), .i_y0 (r_y0),
    .i_x1 (r_x1), .i_y1 (r_y1),
    .i_x2 (r_x2), .i_y2 (r_y2),
    .i_px (r_cx), .i_py (r_cy),
    .o_cov(w_cov)
  );

  assign w_stall   = r_po && !out_rdy;
  assign w_acc     = r_po && out_rdy;
  // The cursor is compared against the box edge before it is incremented,
  // so a coordinate of 2^CW-1 never wraps.
  assign w_row_end = (r_cx == r_xmax);
  assign w_box_end = w_row_end && (r_cy == r_ymax);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    w_nxt = r_state;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (r_state)
      IDLE:  if (nt) w_nxt = LOAD1;
      LOAD1: begin busy = 1'b1; w_nxt = LOAD2; end
      LOAD2: begin busy = 1'b1; w_nxt = SETUP; end
      SETUP: begin
        busy  = 1'b1;
        w_nxt = (w_area == '0) ? DONE : SCAN;
      end
      // Leave only once the final position has been evaluated and nothing is
      // still waiting on the consumer.
      SCAN: begin
        busy = 1'b1;
        if (r_last && !w_stall) w_nxt = DONE;
      end
      DONE:  begin done = 1'b1; w_nxt = IDLE; end
      default: w_nxt = IDLE;
    endcase
  end

  // Vertex capture, bbox setup, cursor walk, pixel output register and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x0 <= '0; r_y0 <= '0; r_x1 <= '0; r_y1 <= '0; r_x2 <= '0; r_y2 <= '0;
      r_xmin <= '0; r_xmax <= '0; r_ymin <= '0; r_ymax <= '0;
      r_cx <= '0; r_cy <= '0;
      r_last <= 1'b0;
      r_po   <= 1'b0;
      r_xo   <= '0;
      r_yo   <= '0;
      r_cnt  <= '0;
    end else begin
      unique case (r_state)
        IDLE:  if (nt) begin r_x0 <= xi; r_y0 <= yi; end
        LOAD1: begin r_x1 <= xi; r_y1 <= yi; end
        LOAD2: begin r_x2 <= xi; r_y2 <= yi; end
        SETUP: begin
          r_xmin <= w_xmin; r_xmax <= w_xmax;
          r_ymin <= w_ymin; r_ymax <= w_ymax;
          r_cx   <= w_xmin;
          r_cy   <= w_ymin;
          r_last <= 1'b0;
          r_po   <= 1'b0;
        end
        SCAN: begin
          if (!w_stall) begin
            if (!r_last) begin
              r_po <= w_cov;
              if (w_cov) begin
                r_xo <= r_cx;
                r_yo <= r_cy;
              end
              if (w_box_end) begin
                r_last <= 1'b1;
              end else if (w_row_end) begin
                r_cx <= r_xmin;
                r_cy <= r_cy + CW'(1);
              end else begin
                r_cx <= r_cx + CW'(1);
              end
            end else begin
              r_po <= 1'b0;
            end
          end
        end
        default: ;
      endcase

      if ((r_state == IDLE) && nt) r_cnt <= '0;
      else if (w_acc)              r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign po      = r_po;
  assign xo      = r_xo;
  assign yo      = r_yo;
  assign pix_cnt = r_cnt;

endmodule
